// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the memory slave and its helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Width of a word index into a memory of the given depth (at least 1 bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Low-address mask that must be zero for an access of the given size.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    return (8'd1 << size) - 8'd1;
  endfunction

endpackage

// File: rtl/ahb_mem_bytelane.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module ahb_mem_bytelane
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
)(
  input  logic                          clk,
  input  logic                          we,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [idx_width(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [idx_width(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: decodes each accepted beat, inserts programmable
// wait states, answers illegal accesses with a two-cycle ERROR, and performs
// byte-lane writes into the backing store.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
)(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef logic [ADDR_WIDTH:0]   lim_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam lim_t LIMIT = lim_t'(DEPTH * NB);

  state_e            state, state_nxt;
  logic [3:0]        wcnt;
  addr_t             addr_q;
  logic              write_q;
  hsize_e            size_q;
  htrans_e           trans;
  logic              open_slot, accept;
  logic              out_of_range, size_bad, misalign, illegal;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  word_idx;
  logic [NB-1:0]     be;
  logic              mem_we;
  logic [DATA_WIDTH-1:0] rd_data;
  logic              unused_bits;

  // A new address phase can only be taken in a cycle that is completing
  // (or idle); WAIT and ERR1 hold HREADYOUT low, so nothing is taken there.
  assign trans     = htrans_e'(HTRANS);
  assign open_slot = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept    = HSEL && HREADY && open_slot &&
                     ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  // Legality of the beat being presented: range, size and alignment.
  assign out_of_range = ({1'b0, HADDR} >= LIMIT);
  assign size_bad     = (HSIZE > 3'(OFF_W));
  assign misalign     = |(HADDR & addr_t'(size_mask(HSIZE)));
  assign illegal      = out_of_range || size_bad || misalign;

  // Address-phase capture of the accepted beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else if (accept) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      size_q  <= hsize_e'(HSIZE);
    end
  end

  // Wait-state counter: loaded on a legal accept, counts down through WAIT.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wcnt <= '0;
    end else if (accept && !illegal && (WS != 4'd0)) begin
      wcnt <= WS;
    end else if (state == ST_WAIT) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; errors bypass the wait states entirely.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (illegal)              state_nxt = ST_ERR1;
          else if (WS != 4'd0)      state_nxt = ST_WAIT;
          else                      state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT:  state_nxt = (wcnt <= 4'd1) ? ST_DATA : ST_WAIT;
      ST_ERR1:  state_nxt = ST_ERR2;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs per state; read data is only driven in DATA.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: HRDATA    = rd_data;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP     = HRESP_ERROR;
      default: ;
    endcase
  end

  assign off      = addr_q[OFF_W-1:0];
  assign word_idx = addr_q[OFF_W +: IDX_W];

  // Byte enables: 2**size_q consecutive lanes starting at the byte offset.
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(off)) && (i < (int'(off) + (1 << size_q)));
    end
  end

  // Writes commit on the edge that ends DATA; erroring beats never get here.
  assign mem_we = (state == ST_DATA) && write_q;

  ahb_mem_bytelane #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (be),
    .waddr (word_idx),
    .wdata (HWDATA),
    .raddr (word_idx),
    .rdata (rd_data)
  );

  // Burst type, protection and upper address bits carry no meaning here.
  assign unused_bits = ^{HBURST, HPROT, addr_q[ADDR_WIDTH-1:IDX_W+OFF_W]};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one instance with no wait states and one with
// two, driven by a pipelined AHB-Lite master and checked against a byte-array
// reference memory.
module tb_ahb_lite_mem_slave;

  localparam int DEPTH = 1024;
  localparam int LIM   = DEPTH * 4;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } xf_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel_v      [2];
  logic [31:0] haddr_v     [2];
  logic        hwrite_v    [2];
  logic [2:0]  hsize_v     [2];
  logic [1:0]  htrans_v    [2];
  logic [31:0] hwdata_v    [2];
  logic [31:0] hrdata_v    [2];
  logic        hreadyout_v [2];
  logic        hresp_v     [2];
  logic        hready_v    [2];

  int          vectors     = 0;
  int          miscompares = 0;
  xf_t         q[$];
  logic [7:0]  mdl [2][LIM];
  logic [31:0] last_rd;
  int          dcyc;

  always #5 HCLK = ~HCLK;

  assign hready_v[0] = hreadyout_v[0];
  assign hready_v[1] = hreadyout_v[1];

  ahb_lite_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_v[0]), .HADDR(haddr_v[0]),
    .HWRITE(hwrite_v[0]), .HSIZE(hsize_v[0]), .HBURST(3'b000), .HPROT(4'b0011),
    .HTRANS(htrans_v[0]), .HREADY(hready_v[0]), .HWDATA(hwdata_v[0]),
    .HRDATA(hrdata_v[0]), .HREADYOUT(hreadyout_v[0]), .HRESP(hresp_v[0]));

  ahb_lite_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_v[1]), .HADDR(haddr_v[1]),
    .HWRITE(hwrite_v[1]), .HSIZE(hsize_v[1]), .HBURST(3'b001), .HPROT(4'b0011),
    .HTRANS(htrans_v[1]), .HREADY(hready_v[1]), .HWDATA(hwdata_v[1]),
    .HRDATA(hrdata_v[1]), .HREADYOUT(hreadyout_v[1]), .HRESP(hresp_v[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: in range, size at most a word, naturally aligned.
  function automatic bit legal(input xf_t x);
    return (x.addr < 32'(LIM)) && (x.size <= 3'd2) &&
           ((x.addr % (32'd1 << x.size)) == 32'd0);
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  // Little-endian lane placement: byte at address a sits in lane a%4.
  task automatic mwrite(input int d, input xf_t x);
    int a;
    a = int'(x.addr);
    for (int i = 0; i < (1 << x.size); i++)
      mdl[d][a+i] = x.wdata[8*((a % 4) + i) +: 8];
  endtask

  task automatic add(input logic [31:0] a, input bit w, input logic [2:0] s,
                     input logic [31:0] wd, input logic [1:0] t);
    xf_t x;
    x.addr = a; x.wr = w; x.size = s; x.wdata = wd; x.trans = t;
    q.push_back(x);
  endtask

  task automatic drive_addr(input int d, input int ai);
    if (ai < q.size()) begin
      hsel_v[d]   = 1'b1;
      haddr_v[d]  = q[ai].addr;
      hwrite_v[d] = q[ai].wr;
      hsize_v[d]  = q[ai].size;
      htrans_v[d] = q[ai].trans;
    end else begin
      hsel_v[d]   = 1'b0;
      haddr_v[d]  = '0;
      hwrite_v[d] = 1'b0;
      hsize_v[d]  = '0;
      htrans_v[d] = 2'b00;
    end
  endtask

  // Pipelined master: issues the queued beats back to back on DUT d and
  // checks every data phase against the reference memory.
  task automatic run_q(input int d);
    int ai, budget, wcnt, ws;
    bit dv;
    xf_t dx;
    logic r, rs;
    logic [31:0] rd;
    ws = (d == 0) ? 0 : 2;
    ai = 0; dv = 0; wcnt = 0; dcyc = 0;
    budget = 6 * q.size() + 20;
    drive_addr(d, ai);
    while ((ai < q.size() || dv) && budget > 0) begin
      @(negedge HCLK);
      budget--;
      r = hreadyout_v[d]; rs = hresp_v[d]; rd = hrdata_v[d];
      if (dv) begin
        dcyc++;
        if (!r) begin
          wcnt++;
          chk("stall_resp", {31'b0, rs}, {31'b0, !legal(dx)});
          chk("stall_rdata", rd, 32'h0);
        end else begin
          chk("data_phase_waits", 32'(wcnt), legal(dx) ? 32'(ws) : 32'd1);
          chk("resp", {31'b0, rs}, {31'b0, !legal(dx)});
          if (!legal(dx)) chk("err_rdata", rd, 32'h0);
          else if (!dx.wr) begin
            chk("rdata", rd, mword(d, dx.addr));
            last_rd = rd;
          end else mwrite(d, dx);
          dv = 0;
        end
      end else begin
        chk("idle_ready", {31'b0, r}, 32'd1);
        chk("idle_resp", {31'b0, rs}, 32'd0);
        chk("idle_rdata", rd, 32'h0);
      end
      if (r && ai < q.size()) begin
        if (q[ai].trans[1]) begin
          dv = 1; dx = q[ai]; wcnt = 0;
        end
        ai++;
      end
      @(posedge HCLK); #1;
      drive_addr(d, ai);
      hwdata_v[d] = (dv && dx.wr) ? dx.wdata : $urandom();
    end
    chk("seq_completed", {31'b0, budget > 0}, 32'd1);
    q.delete();
  endtask

  task automatic add_random(input int n);
    xf_t x;
    int kind, t;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      t    = $urandom_range(0, 9);
      x.wr    = 1'($urandom_range(0, 1));
      x.wdata = $urandom();
      x.trans = (t == 0) ? 2'b01 : (t == 1) ? 2'b00 : (t < 6) ? 2'b10 : 2'b11;
      if (kind == 0) begin
        x.size = 3'd2;
        x.addr = 32'(LIM) + 32'($urandom_range(0, 255) * 4);
      end else if (kind == 1) begin
        x.size = 3'($urandom_range(1, 2));
        x.addr = 32'($urandom_range(0, 127) * 4) +
                 ((x.size == 3'd1) ? 32'd1 : 32'($urandom_range(1, 3)));
      end else if (kind == 2) begin
        x.size = 3'd3;
        x.addr = 32'($urandom_range(0, 63) * 8);
      end else begin
        x.size = 3'($urandom_range(0, 2));
        x.addr = 32'($urandom_range(0, 511)) & ~((32'd1 << x.size) - 32'd1);
      end
      q.push_back(x);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hsel_v[d] = 1'b0; haddr_v[d] = '0; hwrite_v[d] = 1'b0;
      hsize_v[d] = '0; htrans_v[d] = 2'b00; hwdata_v[d] = '0;
    end
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {31'b0, hreadyout_v[d]}, 32'd1);
      chk("reset_resp", {31'b0, hresp_v[d]}, 32'd0);
      chk("reset_rdata", hrdata_v[d], 32'h0);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Known contents for the low 512 bytes of both memories.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 128; w++) add(32'(w * 4), 1'b1, 3'd2, 32'h0, 2'b10);
      run_q(d);
    end

    // Word write then read, no wait states.
    add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
    add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(0);
    chk("word_rw", last_rd, 32'hDEADBEEF);

    // Byte lanes.
    add(32'h20, 1'b1, 3'd2, 32'h00000000, 2'b10);
    add(32'h21, 1'b1, 3'd0, 32'h0000AA00, 2'b10);
    add(32'h23, 1'b1, 3'd0, 32'h55000000, 2'b10);
    add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(0);
    chk("byte_lanes", last_rd, 32'h5500AA00);

    // Out-of-range read, misaligned halfword write leaves memory alone.
    add(32'(LIM), 1'b0, 3'd2, 32'h0, 2'b10);
    add(32'h11, 1'b1, 3'd1, 32'h0000FFFF, 2'b10);
    add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(0);
    chk("misaligned_no_write", last_rd, 32'hDEADBEEF);

    // Write immediately followed by a read of the same word.
    add(32'h40, 1'b1, 3'd2, 32'h12345678, 2'b10);
    add(32'h40, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(0);
    chk("pipelined_rw", last_rd, 32'h12345678);

    // Two wait states: single read, then a 4-beat burst.
    add(32'h8, 1'b1, 3'd2, 32'hA5A5_0F0F, 2'b10);
    add(32'h8, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(1);
    chk("ws2_read", last_rd, 32'hA5A5_0F0F);
    add(32'h0, 1'b0, 3'd2, 32'h0, 2'b10);
    add(32'h4, 1'b0, 3'd2, 32'h0, 2'b11);
    add(32'h8, 1'b0, 3'd2, 32'h0, 2'b11);
    add(32'hC, 1'b0, 3'd2, 32'h0, 2'b11);
    run_q(1);
    chk("burst_data_cycles", 32'(dcyc), 32'd12);

    // Randomized traffic on both instances.
    add_random(60);
    run_q(0);
    add_random(60);
    run_q(1);

    // Reset during the WAIT of a write drops it.
    hsel_v[1] = 1'b1; haddr_v[1] = 32'h80; hwrite_v[1] = 1'b1;
    hsize_v[1] = 3'd2; htrans_v[1] = 2'b10;
    @(posedge HCLK); #1;
    hsel_v[1] = 1'b0; htrans_v[1] = 2'b00; hwdata_v[1] = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("rst_pre_wait", {31'b0, hreadyout_v[1]}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_async_ready", {31'b0, hreadyout_v[1]}, 32'd1);
    chk("rst_async_resp", {31'b0, hresp_v[1]}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    add(32'h80, 1'b0, 3'd2, 32'h0, 2'b10);
    run_q(1);
    chk("rst_word_unchanged", last_rd, mword(1, 32'h80));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
